// File: rtl/addsub_pipe_if.sv
// Valid/ready stream bundle for the pipelined adder/subtractor.
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             cin;
  logic             sgn;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, op, cin, sgn, sat, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, op, cin, sgn, sat, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor; the carry chain is cut into
// STAGES segments, one segment per register rank, whole-pipe stall.
module addsub_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  addsub_pipe_if.slave bus
);
  localparam int unsigned SEG = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] fx;
  logic [WIDTH-1:0] fy;
  logic             fc;

  // Inputs to the last segment
  logic [SEG-1:0]   lx;
  logic [SEG-1:0]   ly;
  logic             lc;
  logic             lv;
  logic             lsgn;
  logic             lsat;
  logic [1:0]       lop;
  logic [SEG:0]     lseg;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;
  logic             c_msb;
  logic             sovf;
  logic             is_sub;
  logic             ovf_sel;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  assign advance       = bus.out_ready | ~out_valid_q;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

  // Subtraction is X + ~Y + 1 with the operands ordered by op
  always_comb begin
    fx = bus.a;
    fy = bus.b;
    fc = 1'b0;
    case (bus.op)
      2'b01: begin
        fy = ~bus.b;
        fc = 1'b1;
      end
      2'b11: begin
        fx = bus.b;
        fy = ~bus.a;
        fc = 1'b1;
      end
      2'b10: fc = bus.cin;
      default: ;
    endcase
  end

  // Intermediate ranks: each adds one segment and keeps only unconsumed
  // operand bits and already produced sum bits.
  for (genvar s = 0; s < STAGES - 1; s++) begin : g_rank
    localparam int unsigned REM  = WIDTH - (s + 1) * SEG;
    localparam int unsigned DONE = (s + 1) * SEG;

    logic            v_q;
    logic            sgn_q;
    logic            sat_q;
    logic            c_q;
    logic [1:0]      op_q;
    logic [REM-1:0]  x_q;
    logic [REM-1:0]  y_q;
    logic [DONE-1:0] sum_q;

    logic [SEG-1:0]  sx;
    logic [SEG-1:0]  sy;
    logic            sc;
    logic [SEG:0]    seg;
    logic [REM-1:0]  fwd_x;
    logic [REM-1:0]  fwd_y;
    logic [DONE-1:0] fwd_sum;
    logic            fwd_v;
    logic            fwd_sgn;
    logic            fwd_sat;
    logic [1:0]      fwd_op;

    if (s == 0) begin : g_src
      assign sx      = fx[SEG-1:0];
      assign sy      = fy[SEG-1:0];
      assign sc      = fc;
      assign fwd_x   = fx[WIDTH-1:SEG];
      assign fwd_y   = fy[WIDTH-1:SEG];
      assign fwd_sum = seg[SEG-1:0];
      assign fwd_v   = bus.in_valid;
      assign fwd_sgn = bus.sgn;
      assign fwd_sat = bus.sat;
      assign fwd_op  = bus.op;
    end else begin : g_src
      assign sx      = g_rank[s-1].x_q[SEG-1:0];
      assign sy      = g_rank[s-1].y_q[SEG-1:0];
      assign sc      = g_rank[s-1].c_q;
      assign fwd_x   = g_rank[s-1].x_q[REM+SEG-1:SEG];
      assign fwd_y   = g_rank[s-1].y_q[REM+SEG-1:SEG];
      assign fwd_sum = {seg[SEG-1:0], g_rank[s-1].sum_q};
      assign fwd_v   = g_rank[s-1].v_q;
      assign fwd_sgn = g_rank[s-1].sgn_q;
      assign fwd_sat = g_rank[s-1].sat_q;
      assign fwd_op  = g_rank[s-1].op_q;
    end

    assign seg = {1'b0, sx} + {1'b0, sy} + (SEG+1)'(sc);

    // Rank register, holds on stall
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        sgn_q <= 1'b0;
        sat_q <= 1'b0;
        c_q   <= 1'b0;
        op_q  <= '0;
        x_q   <= '0;
        y_q   <= '0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= fwd_v;
        sgn_q <= fwd_sgn;
        sat_q <= fwd_sat;
        c_q   <= seg[SEG];
        op_q  <= fwd_op;
        x_q   <= fwd_x;
        y_q   <= fwd_y;
        sum_q <= fwd_sum;
      end
    end
  end

  if (STAGES == 1) begin : g_last_src
    assign lx   = fx;
    assign ly   = fy;
    assign lc   = fc;
    assign lv   = bus.in_valid;
    assign lop  = bus.op;
    assign lsgn = bus.sgn;
    assign lsat = bus.sat;
    assign raw  = lseg[SEG-1:0];
  end else begin : g_last_src
    assign lx   = g_rank[STAGES-2].x_q;
    assign ly   = g_rank[STAGES-2].y_q;
    assign lc   = g_rank[STAGES-2].c_q;
    assign lv   = g_rank[STAGES-2].v_q;
    assign lop  = g_rank[STAGES-2].op_q;
    assign lsgn = g_rank[STAGES-2].sgn_q;
    assign lsat = g_rank[STAGES-2].sat_q;
    assign raw  = {lseg[SEG-1:0], g_rank[STAGES-2].sum_q};
  end

  assign lseg = {1'b0, lx} + {1'b0, ly} + (SEG+1)'(lc);

  // Overflow in the selected domain and saturation of the final result
  always_comb begin
    c_msb   = raw[WIDTH-1] ^ lx[SEG-1] ^ ly[SEG-1];
    sovf    = c_msb ^ lseg[SEG];
    is_sub  = (lop == 2'b01) || (lop == 2'b11);
    ovf_sel = lsgn ? sovf : (is_sub ? ~lseg[SEG] : lseg[SEG]);
    res     = raw;
    if (lsat && ovf_sel) begin
      if (lsgn) begin
        // Raw MSB set means the true result was positive
        res = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        res = is_sub ? '0 : '1;
      end
    end
  end

  // Output rank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= lv;
      result_q    <= res;
      cout_q      <= lseg[SEG];
      ovf_q       <= ovf_sel;
      zero_q      <= (res == '0);
      neg_q       <= res[WIDTH-1];
    end
  end
endmodule
